irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Eight-source vectored interrupt controller for the 16-bit pipelined core. It latches peripheral interrupt lines and applies per-source enable and trigger mode. It presents one request with a jump vector to the fetch stage, tracks nested in-service levels, and exposes a small register file on the data-memory bus so software can configure it.

## Interface
Parameters:
- CPU_WIDTH, 16, datapath/vector width
- NUM_IRQ, 8, number of sources; index 0 is highest priority
- VEC_SHIFT, 2, vector spacing; vector = VECBASE + (id << VEC_SHIFT)

Ports:
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous active-high reset
- irq  in  NUM_IRQ  peripheral interrupt lines, synchronous to clk
- cfg_sel  in  1  register-file access strobe, decoded from mem_addr
- cfg_addr  in  3  register offset
- cfg_we  in  1  write enable, qualified by cfg_sel
- cfg_wdata  in  CPU_WIDTH  write data
- cfg_rdata  out  CPU_WIDTH  combinational read data; 0 when cfg_sel=0
- irq_req  out  1  request to fetch stage
- irq_vec  out  CPU_WIDTH  handler address; valid while irq_req=1
- irq_ack  in  1  fetch stage took the vector (one-cycle pulse)
- irq_ret  in  1  return-from-interrupt executed (one-cycle pulse)

## Operation
Register map (cfg_addr):
- 0 CTRL: bit0 GIE (global enable); other bits read as 0.
- 1 ENABLE: per-source mask.
- 2 TRIG: 1=edge, 0=level.
- 3 PENDING: reads pending bits; writing 1 clears edge-pending bits (W1C); level bits ignore writes.
- 4 INSERVICE: read-only.
- 5 VECBASE: full-width vector base.
- 6–7: reserved; read 0, writes ignored.

Pending rules:
- Edge source: bit sets when irq[i]=1 and irq_q[i]=0 (irq_q is the previous-cycle sample). It clears on ack of that source or on a W1C write.
- Edge set and W1C clear in the same cycle: set wins.
- Level source: pending[i] = registered irq[i].

Eligibility: eligible = pending & ENABLE & ~INSERVICE, gated by GIE. The winning candidate is the lowest set index. It may issue only if its index is lower than the lowest set INSERVICE bit, or INSERVICE=0.

State machine:
- IDLE: if a candidate is eligible, latch id and vector, then go to REQ.
- REQ: irq_req=1; irq_vec and id are frozen. On irq_ack, set INSERVICE[id], clear pending[id] if the source is edge-triggered, and return to IDLE.
- REQ is not withdrawn if the source is disabled, cleared, or preempted before ack. The handler must tolerate a spurious entry.

Return handling:
- irq_ret clears the lowest set INSERVICE bit. It has no effect when INSERVICE=0.
- irq_ret and irq_ack in the same cycle: apply ret first, then the ack set.

Arithmetic: vector = VECBASE + (id << VEC_SHIFT), computed modulo 2^CPU_WIDTH (wraps).

## Timing
- Reset values: all registers, irq_q, pending and INSERVICE are 0; state is IDLE; irq_req=0; irq_vec=0. cfg_rdata is 0 while cfg_sel=0.
- Reset mid-REQ drops irq_req on the next cycle, with no ack side effects.
- Edge on irq at cycle t: pending is visible at t+1 and irq_req at t+2.
- Ack at cycle a: irq_req=0 at a+1. The earliest next request is a+2.
- Config write at cycle w takes effect at w+1. A read returns the current register value in the same cycle.
- Back-to-back acks are impossible: at least one IDLE cycle separates requests.

## Structure
- Package irq_pkg holds:
  - register offset constants (CTRL..VECBASE);
  - state enum {IDLE, REQ};
  - default VEC_SHIFT.
- One sub-module, irq_prio_enc: lowest-index-first encoder over NUM_IRQ bits, outputting valid and id. It is instantiated twice: once for eligible candidates and once for the lowest in-service level.

## Test plan
- Single edge: GIE=1, ENABLE=0x01, TRIG=0x01, VECBASE=0x0100, pulse irq[0] at t → irq_req at t+2 with irq_vec=0x0100; ack → INSERVICE=0x01, PENDING=0x00; ret → INSERVICE=0x00.
- Priority: irq[5] and irq[2] rise together (edge, enabled, base 0) → vector 0x0008 first. After ack and ret, the second request is vector 0x0014.
- Nesting: in service on id 3. Pulse irq[1] → request with vec=base+4. Pulse irq[6] → no request until both rets complete, then vec=base+0x18.
- Level mode: TRIG=0, irq[4] held high → request, ack, no re-request while INSERVICE[4]=1. After ret, re-request 2 cycles later; deassert irq[4] → no request.
- Masking/W1C: GIE=0 with an edge on irq[0] → PENDING=0x01, no request. Write PENDING=0x01 in the same cycle as a new edge → bit stays 1. Then set GIE=1 → request.
- Reset in REQ: assert rst while irq_req=1 → next cycle irq_req=0, all registers read 0.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the vectored interrupt controller: register offsets,
// controller state encoding and the default vector spacing.
package irq_pkg;

    localparam logic [2:0] REG_CTRL      = 3'd0;
    localparam logic [2:0] REG_ENABLE    = 3'd1;
    localparam logic [2:0] REG_TRIG      = 3'd2;
    localparam logic [2:0] REG_PENDING   = 3'd3;
    localparam logic [2:0] REG_INSERVICE = 3'd4;
    localparam logic [2:0] REG_VECBASE   = 3'd5;

    localparam int DEF_VEC_SHIFT = 2;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: reports whether any bit is set and the
// index of the lowest set bit (index 0 is the highest priority).
module irq_prio_enc #(
    parameter int N   = 8,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   vec_i,
    output logic           valid_o,
    output logic [IDW-1:0] id_o
);

    always_comb begin
        valid_o = |vec_i;
        id_o    = '0;
        // Scan from the top so the lowest set index is the final assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                id_o = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Eight-source vectored interrupt controller: latches interrupt lines, applies
// enable/trigger mode, issues one vectored request and tracks nested levels.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int CPU_WIDTH = 16,
    parameter int NUM_IRQ   = 8,
    parameter int VEC_SHIFT = DEF_VEC_SHIFT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_IRQ-1:0]   irq,
    input  logic                 cfg_sel,
    input  logic [2:0]           cfg_addr,
    input  logic                 cfg_we,
    input  logic [CPU_WIDTH-1:0] cfg_wdata,
    output logic [CPU_WIDTH-1:0] cfg_rdata,
    output logic                 irq_req,
    output logic [CPU_WIDTH-1:0] irq_vec,
    input  logic                 irq_ack,
    input  logic                 irq_ret
);

    localparam int IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    irq_state_e           state_q, state_d;
    logic                 gie_q, gie_d;
    logic [NUM_IRQ-1:0]   enable_q, enable_d;
    logic [NUM_IRQ-1:0]   trig_q, trig_d;
    logic [NUM_IRQ-1:0]   irq_q;
    logic [NUM_IRQ-1:0]   epend_q, epend_d;
    logic [NUM_IRQ-1:0]   insvc_q, insvc_d;
    logic [CPU_WIDTH-1:0] vecbase_q, vecbase_d;
    logic [CPU_WIDTH-1:0] vec_q, vec_d;
    logic [IDW-1:0]       id_q, id_d;

    logic [NUM_IRQ-1:0]   pending;
    logic [NUM_IRQ-1:0]   eligible;
    logic [NUM_IRQ-1:0]   edge_set;
    logic [NUM_IRQ-1:0]   svc_oh;
    logic                 cand_valid, svc_valid;
    logic [IDW-1:0]       cand_id, svc_id;
    logic                 can_issue;
    logic                 cfg_wr;
    logic                 ack_take;
    logic [CPU_WIDTH-1:0] id_ext;
    logic [CPU_WIDTH-1:0] vec_next;

    // Edge bits live in epend_q; level sources show the registered line directly.
    assign pending  = (epend_q & trig_q) | (irq_q & ~trig_q);
    assign eligible = gie_q ? (pending & enable_q & ~insvc_q) : '0;
    assign edge_set = irq & ~irq_q & trig_q;
    assign cfg_wr   = cfg_sel & cfg_we;
    assign ack_take = (state_q == REQ) & irq_ack;

    irq_prio_enc #(.N(NUM_IRQ), .IDW(IDW)) u_cand_enc (
        .vec_i   (eligible),
        .valid_o (cand_valid),
        .id_o    (cand_id)
    );

    irq_prio_enc #(.N(NUM_IRQ), .IDW(IDW)) u_svc_enc (
        .vec_i   (insvc_q),
        .valid_o (svc_valid),
        .id_o    (svc_id)
    );

    assign svc_oh    = svc_valid ? (NUM_IRQ'(1) << svc_id) : '0;
    assign can_issue = cand_valid & (~svc_valid | (cand_id < svc_id));
    assign id_ext    = CPU_WIDTH'(cand_id);
    assign vec_next  = vecbase_q + (id_ext << VEC_SHIFT);

    // Configuration registers, pending and in-service bookkeeping.
    always_comb begin
        gie_d     = gie_q;
        enable_d  = enable_q;
        trig_d    = trig_q;
        vecbase_d = vecbase_q;
        epend_d   = epend_q;
        insvc_d   = insvc_q & ~(irq_ret ? svc_oh : '0);
        if (ack_take) begin
            insvc_d[id_q] = 1'b1;
            epend_d[id_q] = 1'b0;
        end
        if (cfg_wr) begin
            case (cfg_addr)
                REG_CTRL:    gie_d     = cfg_wdata[0];
                REG_ENABLE:  enable_d  = cfg_wdata[NUM_IRQ-1:0];
                REG_TRIG:    trig_d    = cfg_wdata[NUM_IRQ-1:0];
                REG_PENDING: epend_d   = epend_d & ~cfg_wdata[NUM_IRQ-1:0];
                REG_VECBASE: vecbase_d = cfg_wdata;
                default:     ;
            endcase
        end
        // A fresh edge in the same cycle as a clear keeps the bit set.
        epend_d = (epend_d | edge_set) & trig_q;
    end

    // Handshake: irq_req stays high with irq_vec frozen from the cycle a
    // candidate is latched until the cycle irq_ack is sampled; it is never
    // withdrawn early, and at least one IDLE cycle separates requests.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        vec_d   = vec_q;
        case (state_q)
            IDLE: begin
                if (can_issue) begin
                    id_d    = cand_id;
                    vec_d   = vec_next;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gie_q     <= 1'b0;
            enable_q  <= '0;
            trig_q    <= '0;
            irq_q     <= '0;
            epend_q   <= '0;
            insvc_q   <= '0;
            vecbase_q <= '0;
            vec_q     <= '0;
            id_q      <= '0;
        end else begin
            state_q   <= state_d;
            gie_q     <= gie_d;
            enable_q  <= enable_d;
            trig_q    <= trig_d;
            irq_q     <= irq;
            epend_q   <= epend_d;
            insvc_q   <= insvc_d;
            vecbase_q <= vecbase_d;
            vec_q     <= vec_d;
            id_q      <= id_d;
        end
    end

    always_comb begin
        cfg_rdata = '0;
        if (cfg_sel) begin
            case (cfg_addr)
                REG_CTRL:      cfg_rdata = CPU_WIDTH'(gie_q);
                REG_ENABLE:    cfg_rdata = CPU_WIDTH'(enable_q);
                REG_TRIG:      cfg_rdata = CPU_WIDTH'(trig_q);
                REG_PENDING:   cfg_rdata = CPU_WIDTH'(pending);
                REG_INSERVICE: cfg_rdata = CPU_WIDTH'(insvc_q);
                REG_VECBASE:   cfg_rdata = vecbase_q;
                default:       cfg_rdata = '0;
            endcase
        end
    end

    assign irq_req = (state_q == REQ);
    assign irq_vec = vec_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a register-file vector table plus hand-written
// sequences for request timing, priority, nesting, level mode, W1C and reset.
module tb_irq_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  irq;
    logic        cfg_sel;
    logic [2:0]  cfg_addr;
    logic        cfg_we;
    logic [15:0] cfg_wdata;
    logic [15:0] cfg_rdata;
    logic        irq_req;
    logic [15:0] irq_vec;
    logic        irq_ack;
    logic        irq_ret;

    int total;
    int bad;

    irq_ctrl #(.CPU_WIDTH(16), .NUM_IRQ(8), .VEC_SHIFT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq       (irq),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_we    (cfg_we),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .irq_req   (irq_req),
        .irq_vec   (irq_vec),
        .irq_ack   (irq_ack),
        .irq_ret   (irq_ret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        sel;
        logic        we;
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } cfg_vec_t;

    cfg_vec_t tbl[12];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cfg_write(input logic [2:0] addr, input logic [15:0] data);
        cfg_sel   = 1'b1;
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        @(negedge clk);
        cfg_sel   = 1'b0;
        cfg_we    = 1'b0;
    endtask

    task automatic cfg_read(input logic [2:0] addr, input logic [15:0] exp, input string name);
        cfg_sel  = 1'b1;
        cfg_we   = 1'b0;
        cfg_addr = addr;
        #1;
        check(name, cfg_rdata, exp);
        cfg_sel  = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_irq(input logic [7:0] mask);
        irq = mask;
        @(negedge clk);
        irq = 8'h00;
    endtask

    task automatic do_ack();
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
    endtask

    task automatic do_ret();
        irq_ret = 1'b1;
        @(negedge clk);
        irq_ret = 1'b0;
    endtask

    task automatic wait_req(input int max, input string name);
        int n;
        n = 0;
        while (!irq_req && n < max) begin
            @(negedge clk);
            n++;
        end
        check(name, {15'd0, irq_req}, 16'h0001);
    endtask

    task automatic no_req(input int cycles, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (irq_req) seen = 1'b1;
        end
        check(name, {15'd0, seen}, 16'h0000);
    endtask

    task automatic setup(input logic [7:0] en, input logic [7:0] trig,
                         input logic gie, input logic [15:0] base);
        cfg_write(3'd1, {8'h00, en});
        cfg_write(3'd2, {8'h00, trig});
        cfg_write(3'd5, base);
        cfg_write(3'd0, {15'd0, gie});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; irq = '0; cfg_sel = 1'b0; cfg_addr = '0; cfg_we = 1'b0;
        cfg_wdata = '0; irq_ack = 1'b0; irq_ret = 1'b0;

        tbl[0]  = '{1'b1, 1'b1, 3'd0, 16'hFFFF, 16'h0001};
        tbl[1]  = '{1'b1, 1'b1, 3'd1, 16'hA5C3, 16'h00C3};
        tbl[2]  = '{1'b1, 1'b1, 3'd2, 16'h1234, 16'h0034};
        tbl[3]  = '{1'b1, 1'b1, 3'd5, 16'hBEEF, 16'hBEEF};
        tbl[4]  = '{1'b1, 1'b1, 3'd4, 16'h00FF, 16'h0000};
        tbl[5]  = '{1'b1, 1'b1, 3'd6, 16'hFFFF, 16'h0000};
        tbl[6]  = '{1'b1, 1'b1, 3'd7, 16'hFFFF, 16'h0000};
        tbl[7]  = '{1'b1, 1'b0, 3'd1, 16'h0000, 16'h00C3};
        tbl[8]  = '{1'b0, 1'b1, 3'd1, 16'h0000, 16'h0000};
        tbl[9]  = '{1'b1, 1'b0, 3'd1, 16'h0000, 16'h00C3};
        tbl[10] = '{1'b1, 1'b1, 3'd0, 16'h0000, 16'h0000};
        tbl[11] = '{1'b1, 1'b1, 3'd3, 16'hFFFF, 16'h0000};

        // Reset state
        @(negedge clk);
        do_reset();
        check("reset_req", {15'd0, irq_req}, 16'h0000);
        check("reset_vec", irq_vec, 16'h0000);
        for (int a = 0; a < 8; a++) cfg_read(3'(a), 16'h0000, "reset_reg");

        // Register file table
        for (int i = 0; i < 12; i++) begin
            cfg_sel   = tbl[i].sel;
            cfg_we    = tbl[i].we;
            cfg_addr  = tbl[i].addr;
            cfg_wdata = tbl[i].wdata;
            if (tbl[i].we) @(negedge clk);
            cfg_we = 1'b0;
            #1;
            check($sformatf("tbl_%0d", i), cfg_rdata, tbl[i].exp);
            cfg_sel = 1'b0;
            @(negedge clk);
        end

        // Single edge: exact latency
        do_reset();
        setup(8'h01, 8'h01, 1'b1, 16'h0100);
        pulse_irq(8'h01);
        check("edge_req_t1", {15'd0, irq_req}, 16'h0000);
        cfg_read(3'd3, 16'h0001, "edge_pend_t1");
        check("edge_req_t2", {15'd0, irq_req}, 16'h0001);
        check("edge_vec", irq_vec, 16'h0100);
        do_ack();
        check("edge_req_after_ack", {15'd0, irq_req}, 16'h0000);
        cfg_read(3'd4, 16'h0001, "edge_insvc");
        cfg_read(3'd3, 16'h0000, "edge_pend_clr");
        do_ret();
        cfg_read(3'd4, 16'h0000, "edge_ret");

        // Priority between simultaneous edges
        do_reset();
        setup(8'hFF, 8'hFF, 1'b1, 16'h0000);
        pulse_irq(8'h24);
        wait_req(4, "prio_req1");
        check("prio_vec1", irq_vec, 16'h0008);
        do_ack();
        no_req(3, "prio_blocked");
        do_ret();
        wait_req(4, "prio_req2");
        check("prio_vec2", irq_vec, 16'h0014);
        do_ack();
        do_ret();

        // Nesting
        do_reset();
        setup(8'hFF, 8'hFF, 1'b1, 16'h0200);
        pulse_irq(8'h08);
        wait_req(4, "nest_req3");
        check("nest_vec3", irq_vec, 16'h020C);
        do_ack();
        pulse_irq(8'h02);
        wait_req(4, "nest_req1");
        check("nest_vec1", irq_vec, 16'h0204);
        do_ack();
        cfg_read(3'd4, 16'h000A, "nest_insvc");
        pulse_irq(8'h40);
        no_req(5, "nest_block6_a");
        do_ret();
        cfg_read(3'd4, 16'h0008, "nest_ret1");
        no_req(4, "nest_block6_b");
        do_ret();
        cfg_read(3'd4, 16'h0000, "nest_ret2");
        wait_req(4, "nest_req6");
        check("nest_vec6", irq_vec, 16'h0218);
        do_ack();
        do_ret();

        // Level mode
        do_reset();
        setup(8'h10, 8'h00, 1'b1, 16'h0000);
        irq = 8'h10;
        wait_req(4, "lvl_req");
        check("lvl_vec", irq_vec, 16'h0010);
        do_ack();
        cfg_read(3'd3, 16'h0010, "lvl_pend");
        no_req(4, "lvl_no_rereq");
        do_ret();
        check("lvl_req_r1", {15'd0, irq_req}, 16'h0000);
        cfg_read(3'd4, 16'h0000, "lvl_insvc_clr");
        check("lvl_req_r2", {15'd0, irq_req}, 16'h0001);
        irq = 8'h00;
        do_ack();
        do_ret();
        cfg_read(3'd3, 16'h0000, "lvl_pend_low");
        no_req(4, "lvl_no_req_low");

        // Masking and W1C
        do_reset();
        setup(8'h01, 8'h01, 1'b0, 16'h0300);
        pulse_irq(8'h01);
        @(negedge clk);
        cfg_read(3'd3, 16'h0001, "mask_pend");
        no_req(3, "mask_no_req");
        cfg_write(3'd3, 16'h0001);
        cfg_read(3'd3, 16'h0000, "w1c_clear");
        irq = 8'h01;
        cfg_write(3'd3, 16'h0001);
        irq = 8'h00;
        cfg_read(3'd3, 16'h0001, "w1c_set_wins");
        cfg_write(3'd0, 16'h0001);
        wait_req(4, "gie_req");
        check("gie_vec", irq_vec, 16'h0300);

        // Reset while requesting
        rst = 1'b1;
        @(negedge clk);
        check("rst_req_drop", {15'd0, irq_req}, 16'h0000);
        rst = 1'b0;
        check("rst_vec", irq_vec, 16'h0000);
        for (int a = 0; a < 8; a++) cfg_read(3'(a), 16'h0000, "rst_reg");
        no_req(3, "rst_no_req");

        // Vector wraps modulo 2^16
        do_reset();
        setup(8'h04, 8'h04, 1'b1, 16'hFFFC);
        pulse_irq(8'h04);
        wait_req(4, "wrap_req");
        check("wrap_vec", irq_vec, 16'h0004);
        do_ack();
        do_ret();

        // Ack and ret together: ret clears level 3, ack sets level 1
        do_reset();
        setup(8'hFF, 8'hFF, 1'b1, 16'h0000);
        pulse_irq(8'h08);
        wait_req(4, "ackret_req3");
        do_ack();
        pulse_irq(8'h02);
        wait_req(4, "ackret_req1");
        check("ackret_vec1", irq_vec, 16'h0004);
        irq_ack = 1'b1;
        irq_ret = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        irq_ret = 1'b0;
        cfg_read(3'd4, 16'h0002, "ackret_insvc");
        do_ret();
        cfg_read(3'd4, 16'h0000, "ret_final");
        do_ret();
        cfg_read(3'd4, 16'h0000, "ret_empty");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
